lfsr_decrypt_ctrl: RTL

Hardware sequencer that decrypts an LFSR-encrypted message in data memory without software. It reads the 64 encrypted bytes at addresses 64..127, recovers the LFSR start state and tap pattern from the known space-filled preamble, and writes the plaintext to addresses 0..63. It replaces the Program #2 instruction stream as a self-contained controller on the data-memory port, under the same req/ack launch handshake used by top_level.

---
 rtl/lfsr_pkg.sv | 29 ++
 rtl/lfsr_decrypt_ctrl_if.sv | 38 +++
 rtl/lfsr7_step.sv | 16 +
 rtl/lfsr_decrypt_ctrl.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lfsr_pkg                                                             |
// | Shared tap table, FSM state encoding and constants for the decryptor.|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package lfsr_pkg;

    localparam int unsigned N_TAPS = 9;

    localparam logic [6:0] TAPS [N_TAPS] = '{
        7'h60, 7'h48, 7'h78, 7'h72, 7'h6A, 7'h69, 7'h5C, 7'h7E, 7'h7B
    };

    // Plaintext is stored as (char - SPACE_OFS), so a space encrypts to the raw LFSR state.
    localparam logic [7:0] SPACE_OFS = 8'h20;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        CHK0   = 3'd2,
        SEARCH = 3'd3,
        DEC_RD = 3'd4,
        DEC_WR = 3'd5,
        DONE   = 3'd6
    } state_e;

endpackage
`default_nettype wire

// File: rtl/lfsr_decrypt_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lfsr_decrypt_ctrl_if                                                 |
// | Launch handshake plus single-port data-memory bus of the decryptor.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface lfsr_decrypt_ctrl_if;

    logic       req;
    logic       ack;
    logic       busy;
    logic [7:0] mem_addr;
    logic       mem_we;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;

    modport master (
        input  req,
        input  mem_rdata,
        output ack,
        output busy,
        output mem_addr,
        output mem_we,
        output mem_wdata
    );

    modport slave (
        output req,
        output mem_rdata,
        input  ack,
        input  busy,
        input  mem_addr,
        input  mem_we,
        input  mem_wdata
    );

endinterface
`default_nettype wire

// File: rtl/lfsr7_step.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lfsr7_step                                                           |
// | One combinational step of the 7-bit Fibonacci LFSR.                  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module lfsr7_step (
    input  logic [6:0] state,
    input  logic [6:0] taps,
    output logic [6:0] next_state
);

    assign next_state = {state[5:0], ^(state & taps)};

endmodule
`default_nettype wire

// File: rtl/lfsr_decrypt_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lfsr_decrypt_ctrl                                                    |
// | Recovers LFSR seed/taps from the space preamble and decrypts a       |
// | message in data memory. Optional macro PARITY_CHECK_EN counts bytes  |
// | whose bit 7 is not the parity of bits [6:0].                         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module lfsr_decrypt_ctrl
    import lfsr_pkg::*;
#(
    parameter int MSG_LEN  = 64,
    parameter int SRC_BASE = 64,
    parameter int DST_BASE = 0,
    parameter int PRE_CHK  = 9
) (
    input  logic                       clk,
    input  logic                       init_n,
    lfsr_decrypt_ctrl_if.master        bus,
    output logic [3:0]                 ptrn_idx,
    output logic [6:0]                 lfsr_init_o,
    output logic                       err_nomatch,
    output logic [6:0]                 parity_err_cnt
);

    localparam logic [7:0] c_src_base  = 8'(SRC_BASE);
    localparam logic [7:0] c_dst_base  = 8'(DST_BASE);
    localparam logic [7:0] c_load_last = 8'(PRE_CHK + 1);
    localparam logic [7:0] c_msg_last  = 8'(MSG_LEN - 1);
    localparam logic [3:0] c_k_last    = 4'(N_TAPS - 1);

    state_e     r_state;
    logic       r_req_d;
    logic [7:0] r_cnt;
    logic [3:0] r_k;
    logic [6:0] r_pre_buf [PRE_CHK+1];
    logic [6:0] r_lfsr;
    logic [3:0] r_ptrn;
    logic [6:0] r_init;
    logic       r_err;

    logic         w_launch;
    logic [6:0]   w_cand_taps;
    logic [6:0]   w_dec_taps;
    logic [6:0]   w_lfsr_nxt;
    logic [7:0]   w_plain;
    logic [PRE_CHK-1:0] w_step_ok;
    logic         w_match;

    assign w_launch    = (r_state == IDLE) && r_req_d && !bus.req;
    assign w_cand_taps = TAPS[r_k];
    assign w_dec_taps  = TAPS[r_ptrn];

    // Candidate check: walk the seed forward PRE_CHK times and compare every state.
    for (genvar j = 0; j < PRE_CHK; j++) begin : g_chain
        logic [6:0] w_in;
        logic [6:0] w_out;
        if (j == 0) begin : g_first
            assign w_in = r_pre_buf[0];
        end else begin : g_rest
            assign w_in = g_chain[j-1].w_out;
        end
        lfsr7_step u_step (
            .state      (w_in),
            .taps       (w_cand_taps),
            .next_state (w_out)
        );
        assign w_step_ok[j] = (w_out == r_pre_buf[j+1]);
    end

    assign w_match = &w_step_ok;

    lfsr7_step u_dec_step (
        .state      (r_lfsr),
        .taps       (w_dec_taps),
        .next_state (w_lfsr_nxt)
    );

    assign w_plain = {1'b0, bus.mem_rdata[6:0] ^ r_lfsr} + SPACE_OFS;

    // Bus outputs decode straight from state so an async reset drops mem_we at once.
    always_comb begin
        bus.mem_addr  = 8'h00;
        bus.mem_we    = 1'b0;
        bus.mem_wdata = 8'h00;
        case (r_state)
            LOAD, DEC_RD: bus.mem_addr = c_src_base + r_cnt;
            DEC_WR: begin
                bus.mem_addr  = c_dst_base + r_cnt;
                bus.mem_we    = 1'b1;
                bus.mem_wdata = w_plain;
            end
            default: ;
        endcase
    end

    assign bus.busy = (r_state != IDLE) && (r_state != DONE);
    assign bus.ack  = (r_state == DONE);

    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            r_state <= IDLE;
            r_req_d <= 1'b0;
            r_cnt   <= 8'h00;
            r_k     <= 4'h0;
            r_lfsr  <= 7'h00;
            r_ptrn  <= 4'h0;
            r_init  <= 7'h00;
            r_err   <= 1'b0;
            for (int i = 0; i <= PRE_CHK; i++) r_pre_buf[i] <= 7'h00;
        end else begin
            r_req_d <= bus.req;
            case (r_state)
                IDLE: begin
                    if (w_launch) begin
                        r_state <= LOAD;
                        r_cnt   <= 8'h00;
                        r_k     <= 4'h0;
                        r_ptrn  <= 4'h0;
                        r_init  <= 7'h00;
                        r_err   <= 1'b0;
                    end
                end
                LOAD: begin
                    // Read data trails the address by one cycle, hence the offset index.
                    for (int i = 0; i <= PRE_CHK; i++) begin
                        if (r_cnt == 8'(i + 1)) r_pre_buf[i] <= bus.mem_rdata[6:0];
                    end
                    if (r_cnt == c_load_last) r_state <= CHK0;
                    r_cnt <= r_cnt + 8'd1;
                end
                CHK0: begin
                    if (r_pre_buf[0] == 7'h00) begin
                        r_err   <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_k     <= 4'h0;
                        r_state <= SEARCH;
                    end
                end
                SEARCH: begin
                    if (w_match) begin
                        r_ptrn  <= r_k;
                        r_init  <= r_pre_buf[0];
                        r_lfsr  <= r_pre_buf[0];
                        r_cnt   <= 8'h00;
                        r_state <= DEC_RD;
                    end else if (r_k == c_k_last) begin
                        r_err   <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_k <= r_k + 4'd1;
                    end
                end
                DEC_RD: r_state <= DEC_WR;
                DEC_WR: begin
                    r_lfsr <= w_lfsr_nxt;
                    if (r_cnt == c_msg_last) begin
                        r_state <= DONE;
                    end else begin
                        r_cnt   <= r_cnt + 8'd1;
                        r_state <= DEC_RD;
                    end
                end
                DONE: if (bus.req) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ptrn_idx    = r_ptrn;
    assign lfsr_init_o = r_init;
    assign err_nomatch = r_err;

`ifdef PARITY_CHECK_EN
    logic [6:0] r_par_cnt;

    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            r_par_cnt <= 7'h00;
        end else if (w_launch) begin
            r_par_cnt <= 7'h00;
        end else if ((r_state == DEC_WR) && (bus.mem_rdata[7] != ^bus.mem_rdata[6:0])
                     && (r_par_cnt != 7'h7F)) begin
            r_par_cnt <= r_par_cnt + 7'd1;
        end
    end

    assign parity_err_cnt = r_par_cnt;
`else
    logic w_unused_parity;
    assign w_unused_parity = bus.mem_rdata[7];
    assign parity_err_cnt  = 7'h00;
`endif

endmodule
`default_nettype wire
